instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential MIPS instruction encoder and program loader: accepts a stream of symbolic commands (operation, register fields, immediate/target) over a valid/ready handshake. It packs each command into a 32-bit instruction word using the same opcode/funct encoding the control unit decodes, then writes the words into instruction memory at consecutive word addresses. It sits between the testbench/boot source and the instruction memory write port, ahead of the single-cycle core.

## Interface
- `DEPTH`, 64: maximum number of instruction words written per program.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word.
- `CW`, $clog2(DEPTH+1): word-counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; clears count and errors, leaves DONE.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  encoder can accept a command.
- `cmd_op`  in  4  0 LW, 1 SW, 2 ADD, 3 SUB, 4 SLT, 5 MUL, 6 ADDI, 7 BEQ, 8 J, 9–15 illegal.
- `cmd_rs`, `cmd_rt`, `cmd_rd`  in  5 each  register fields.
- `cmd_imm`  in  16  I-type immediate/offset.
- `cmd_target`  in  26  J-type word target.
- `cmd_last`  in  1  final command of the program.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  32  byte address, `BASE_ADDR + 4*count`.
- `imem_wdata`  out  32  encoded instruction.
- `word_count`  out  CW  words written since reset/start.
- `done`  out  1  program complete.
- `err_illegal`  out  1  sticky: illegal `cmd_op` received.
- `err_full`  out  1  sticky: command dropped, count == DEPTH.

## Operation
- **Encoding.**
  - I-type `{op,rs,rt,imm}`: LW op 100011, SW 101011, ADDI 001000, BEQ 000100.
  - R-type `{000000,rs,rt,rd,00000,funct}`: ADD 100000, SUB 100010, SLT 101010, MUL 011100. MUL uses opcode 000000, matching the core decoder.
  - J-type `{000010,target}`.
  - Unused fields are ignored.
- **FSM states: IDLE, WRITE, DONE.**
  - **IDLE:** `cmd_ready=1`. On `cmd_valid` the command is accepted and the encoded word and flags are registered.
    - Legal op and count < DEPTH: go to WRITE.
    - Illegal op: set `err_illegal`, no write.
    - Count == DEPTH: set `err_full`, no write.
    - In both no-write cases, go to DONE if `cmd_last`, otherwise stay in IDLE.
  - **WRITE:** `imem_we=1` for exactly one cycle with registered addr/data. `count` increments at the end of the cycle. Next state is DONE if the registered last flag is set, otherwise IDLE. `cmd_ready=0`.
  - **DONE:** `done=1`, `cmd_ready=0`, outputs hold. `start` returns the FSM to IDLE with count=0 and errors cleared.
- `start` in IDLE clears count and errors. `start` in WRITE is ignored.
- Reset values: state IDLE, `imem_we=0`, `imem_addr=BASE_ADDR`, `imem_wdata=0`, `word_count=0`, `done=0`, `err_*=0`. `cmd_ready=1` from the first cycle after reset.
- Reset asserted during WRITE: the write is suppressed in that cycle (`imem_we=0`) and the count is not incremented.

## Timing
- Acceptance to `imem_we`: 1 cycle. Sustained throughput: 1 word per 2 cycles.
- `cmd_ready` is decoded from state only; there is no combinational path from `cmd_valid`.
- `word_count` reflects the new value in the cycle after the WRITE cycle.
- `done` rises in the cycle after the WRITE of the last command, or in the cycle after acceptance for a dropped last command.
- Address arithmetic is 32-bit modulo; count never exceeds DEPTH, so there is no wrap.

## Structure
- Shared package `mips_isa_pkg` holds:
  - opcode and funct constants (LW, SW, RTYPE, ADDI, BEQ, J, ADD, SUB, SLT, MUL), shared with the control unit;
  - the `cmd_op` code constants;
  - the FSM state encoding.
- One combinational sub-module, `instr_word_pack`: `cmd_*` → 32-bit word plus an `illegal` flag.
- The FSM, counter and error flags live in `instr_encoder`.

## Test plan
- **Reset:** assert `rst` 2 cycles → all outputs at reset values; `cmd_ready=1` after release.
- **ADD:** ADD rs=1 rt=2 rd=3 → one cycle later `imem_we=1`, addr 0x0, data 0x00221820; `word_count=1`.
- **Back-to-back with stalls:** LW rs=0 rt=8 imm=4 then BEQ rs=1 rt=2 imm=0xFFFF, `cmd_valid` held high → 0x8C080004 @0x0, then 0x1022FFFF @0x4. `cmd_ready` is low during each WRITE cycle.
- **Last and restart:** J target=0x10 with `cmd_last` → 0x08000010 written, `done=1` next cycle, `cmd_ready=0`. `start` → IDLE, `word_count=0`.
- **Errors:** `cmd_op=15` → no write, `err_illegal=1`. With DEPTH=2, three legal commands → third not written, `err_full=1`, `word_count=2`.
- **Reset mid-write:** assert `rst` in the WRITE cycle → `imem_we=0`, `word_count` unchanged at 0, FSM in IDLE.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: shared MIPS ISA constants and encoder types.
//   - opcode / funct fields, the same values the core control unit decodes
//   - symbolic command codes accepted on instr_encoder.cmd_op
//   - instr_encoder FSM state encoding
//   - small helpers that pack R/I/J instruction formats
package mips_isa_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;

    // R-type funct codes (instr[5:0]); MUL rides on OPC_RTYPE like the core expects
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011100;

    // Symbolic command codes; 9..15 are illegal
    localparam logic [3:0] CMD_LW   = 4'd0;
    localparam logic [3:0] CMD_SW   = 4'd1;
    localparam logic [3:0] CMD_ADD  = 4'd2;
    localparam logic [3:0] CMD_SUB  = 4'd3;
    localparam logic [3:0] CMD_SLT  = 4'd4;
    localparam logic [3:0] CMD_MUL  = 4'd5;
    localparam logic [3:0] CMD_ADDI = 4'd6;
    localparam logic [3:0] CMD_BEQ  = 4'd7;
    localparam logic [3:0] CMD_J    = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } enc_state_e;

    function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] pack_j(input logic [25:0] target);
        return {OPC_J, target};
    endfunction

endpackage

// File: rtl/instr_word_pack.sv
// instr_word_pack: purely combinational command -> instruction word packer.
// Ports:
//   cmd_op      in  4   symbolic operation (see CMD_* in mips_isa_pkg)
//   cmd_rs/rt/rd in 5   register fields
//   cmd_imm     in  16  I-type immediate / branch offset
//   cmd_target  in  26  J-type word target
//   word        out 32  encoded instruction (0 when illegal)
//   illegal     out 1   cmd_op is not a defined command
module instr_word_pack
    import mips_isa_pkg::*;
(
    input  logic [3:0]  cmd_op,
    input  logic [4:0]  cmd_rs,
    input  logic [4:0]  cmd_rt,
    input  logic [4:0]  cmd_rd,
    input  logic [15:0] cmd_imm,
    input  logic [25:0] cmd_target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (cmd_op)
            CMD_LW:   word = pack_i(OPC_LW,   cmd_rs, cmd_rt, cmd_imm);
            CMD_SW:   word = pack_i(OPC_SW,   cmd_rs, cmd_rt, cmd_imm);
            CMD_ADDI: word = pack_i(OPC_ADDI, cmd_rs, cmd_rt, cmd_imm);
            CMD_BEQ:  word = pack_i(OPC_BEQ,  cmd_rs, cmd_rt, cmd_imm);
            CMD_ADD:  word = pack_r(cmd_rs, cmd_rt, cmd_rd, FN_ADD);
            CMD_SUB:  word = pack_r(cmd_rs, cmd_rt, cmd_rd, FN_SUB);
            CMD_SLT:  word = pack_r(cmd_rs, cmd_rt, cmd_rd, FN_SLT);
            CMD_MUL:  word = pack_r(cmd_rs, cmd_rt, cmd_rd, FN_MUL);
            CMD_J:    word = pack_j(cmd_target);
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts symbolic commands over valid/ready, encodes them and
// writes the words to instruction memory at consecutive word addresses.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               pulse: clear count/errors, leave DONE
//   cmd_valid/ready     command handshake (ready decoded from state only)
//   cmd_op/rs/rt/rd/imm/target/last  command fields
//   imem_we/addr/wdata  instruction-memory write port (one-cycle strobe)
//   word_count          words written since reset/start
//   done                program complete (last command handled)
//   err_illegal         sticky: illegal cmd_op seen
//   err_full            sticky: command dropped because count == DEPTH
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [4:0]    cmd_rs,
    input  logic [4:0]    cmd_rt,
    input  logic [4:0]    cmd_rd,
    input  logic [15:0]   cmd_imm,
    input  logic [25:0]   cmd_target,
    input  logic          cmd_last,
    output logic          imem_we,
    output logic [31:0]   imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [CW-1:0] word_count,
    output logic          done,
    output logic          err_illegal,
    output logic          err_full
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    enc_state_e    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic          err_ill_q, err_ill_d;
    logic          err_full_q, err_full_d;

    logic [31:0]   pk_word;
    logic          pk_illegal;

    instr_word_pack u_pack (
        .cmd_op     (cmd_op),
        .cmd_rs     (cmd_rs),
        .cmd_rt     (cmd_rt),
        .cmd_rd     (cmd_rd),
        .cmd_imm    (cmd_imm),
        .cmd_target (cmd_target),
        .word       (pk_word),
        .illegal    (pk_illegal)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        last_d     = last_q;
        done_d     = done_q;
        err_ill_d  = err_ill_q;
        err_full_d = err_full_q;
        case (state_q)
            ST_IDLE: begin
                // start clears first so a same-cycle command sees count 0
                if (start) begin
                    count_d    = '0;
                    err_ill_d  = 1'b0;
                    err_full_d = 1'b0;
                end
                if (cmd_valid) begin
                    if (pk_illegal) begin
                        err_ill_d = 1'b1;
                        if (cmd_last) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else if (count_d == FULL_CNT) begin
                        err_full_d = 1'b1;
                        if (cmd_last) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = ST_WRITE;
                        addr_d  = BASE_ADDR + (32'(count_d) << 2);
                        wdata_d = pk_word;
                        last_d  = cmd_last;
                    end
                end
            end
            ST_WRITE: begin
                // start is deliberately ignored while a write is in flight
                count_d = count_q + CW'(1);
                if (last_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d    = ST_IDLE;
                    count_d    = '0;
                    done_d     = 1'b0;
                    err_ill_d  = 1'b0;
                    err_full_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            count_q    <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            err_ill_q  <= 1'b0;
            err_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            last_q     <= last_d;
            done_q     <= done_d;
            err_ill_q  <= err_ill_d;
            err_full_q <= err_full_d;
        end
    end

    // Reset arriving during WRITE must kill the strobe in that same cycle,
    // so the registered state is qualified with rst here.
    assign imem_we     = (state_q == ST_WRITE) && !rst;
    assign cmd_ready   = (state_q == ST_IDLE);
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign word_count  = count_q;
    assign done        = done_q;
    assign err_illegal = err_ill_q;
    assign err_full    = err_full_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int DEPTH = 2;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int CW = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_op = '0;
    logic [4:0]    cmd_rs = '0, cmd_rt = '0, cmd_rd = '0;
    logic [15:0]   cmd_imm = '0;
    logic [25:0]   cmd_target = '0;
    logic          cmd_last = 1'b0;
    logic          imem_we;
    logic [31:0]   imem_addr, imem_wdata;
    logic [CW-1:0] word_count;
    logic          done, err_illegal, err_full;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .done(done),
        .err_illegal(err_illegal), .err_full(err_full)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding: field placement by plain shifts; bit 32 = illegal
    function automatic logic [32:0] ref_enc(input int op, input int rs, input int rt,
                                            input int rd, input int imm, input int tgt);
        logic [31:0] rr, ii;
        rr = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11);
        ii = (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        case (op)
            0: return {1'b0, (32'd35 << 26) | ii};
            1: return {1'b0, (32'd43 << 26) | ii};
            2: return {1'b0, rr | 32'd32};
            3: return {1'b0, rr | 32'd34};
            4: return {1'b0, rr | 32'd42};
            5: return {1'b0, rr | 32'd28};
            6: return {1'b0, (32'd8 << 26) | ii};
            7: return {1'b0, (32'd4 << 26) | ii};
            8: return {1'b0, (32'd2 << 26) | 32'(tgt)};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Behavioural model: a write is pending for the cycle after a legal,
    // non-full acceptance; the count moves when that cycle ends.
    bit          m_pend, m_last, m_done, m_ill, m_full;
    int          m_cnt;
    logic [31:0] m_addr, m_data;
    int          c_now;
    logic [32:0] e_now;

    always @(posedge clk) begin
        if (rst) begin
            m_pend <= 0; m_cnt <= 0; m_done <= 0; m_ill <= 0; m_full <= 0;
            m_addr <= BASE; m_data <= 0; m_last <= 0;
        end else if (m_pend) begin
            m_pend <= 0;
            m_cnt  <= m_cnt + 1;
            m_done <= m_last;
        end else if (m_done) begin
            if (start) begin
                m_done <= 0; m_cnt <= 0; m_ill <= 0; m_full <= 0;
            end
        end else begin
            c_now = start ? 0 : m_cnt;
            if (start) begin
                m_cnt <= 0; m_ill <= 0; m_full <= 0;
            end
            if (cmd_valid) begin
                e_now = ref_enc(cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target);
                if (e_now[32]) begin
                    m_ill <= 1; m_done <= cmd_last;
                end else if (c_now == DEPTH) begin
                    m_full <= 1; m_done <= cmd_last;
                end else begin
                    m_pend <= 1; m_last <= cmd_last;
                    m_addr <= BASE + 32'(4 * c_now);
                    m_data <= e_now[31:0];
                end
            end
        end
    end

    // Per-cycle comparison against the model, settled well away from posedge
    always begin
        @(negedge clk);
        #2;
        if (chk_en) begin
            chk("ready", 32'(cmd_ready), 32'(!m_pend && !m_done));
            chk("we", 32'(imem_we), 32'(m_pend && !rst));
            if (m_pend && !rst) begin
                chk("addr", imem_addr, m_addr);
                chk("wdata", imem_wdata, m_data);
            end
            chk("count", 32'(word_count), 32'(m_cnt));
            chk("done", 32'(done), 32'(m_done));
            chk("err_illegal", 32'(err_illegal), 32'(m_ill));
            chk("err_full", 32'(err_full), 32'(m_full));
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int op, input int rs, input int rt, input int rd,
                        input int imm, input int tgt, input bit last);
        int n;
        cmd_valid = 1'b1;
        cmd_op = 4'(op); cmd_rs = 5'(rs); cmd_rt = 5'(rt); cmd_rd = 5'(rd);
        cmd_imm = 16'(imm); cmd_target = 26'(tgt); cmd_last = last;
        n = 0;
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [32:0] e;
        int len, op, n;

        // Model pinned against hand-computed words
        e = ref_enc(2, 1, 2, 3, 0, 0);      chk("ref_add", e[31:0], 32'h0022_1820);
        e = ref_enc(0, 0, 8, 0, 4, 0);      chk("ref_lw", e[31:0], 32'h8C08_0004);
        e = ref_enc(7, 1, 2, 0, 16'hFFFF, 0); chk("ref_beq", e[31:0], 32'h1022_FFFF);
        e = ref_enc(8, 0, 0, 0, 0, 32'h10); chk("ref_j", e[31:0], 32'h0800_0010);
        e = ref_enc(15, 0, 0, 0, 0, 0);     chk("ref_illegal", 32'(e[32]), 32'd1);

        // Reset for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, BASE);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_errs", {30'd0, err_illegal, err_full}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        #1 chk("ready_after_rst", 32'(cmd_ready), 32'd1);
        @(negedge clk);

        // Single ADD
        send(2, 1, 2, 3, 0, 0, 0);
        #1;
        chk("add_we", 32'(imem_we), 32'd1);
        chk("add_addr", imem_addr, 32'h0);
        chk("add_data", imem_wdata, 32'h0022_1820);
        @(negedge clk);
        #1 chk("add_count", 32'(word_count), 32'd1);
        @(negedge clk);
        pulse_start();

        // Back-to-back, valid effectively held
        send(0, 0, 8, 0, 4, 0, 0);
        #1;
        chk("lw_data", imem_wdata, 32'h8C08_0004);
        chk("lw_addr", imem_addr, 32'h0);
        chk("lw_ready", 32'(cmd_ready), 32'd0);
        send(7, 1, 2, 0, 16'hFFFF, 0, 0);
        #1;
        chk("beq_data", imem_wdata, 32'h1022_FFFF);
        chk("beq_addr", imem_addr, 32'h4);
        chk("beq_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);

        // Third legal command with DEPTH=2 is dropped
        send(3, 4, 5, 6, 0, 0, 0);
        #1;
        chk("full_we", 32'(imem_we), 32'd0);
        chk("full_flag", 32'(err_full), 32'd1);
        chk("full_count", 32'(word_count), 32'd2);
        @(negedge clk);

        // Illegal op
        send(15, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ill_we", 32'(imem_we), 32'd0);
        chk("ill_flag", 32'(err_illegal), 32'd1);
        @(negedge clk);
        pulse_start();
        #1 chk("start_clr", {30'd0, err_illegal, err_full}, 32'd0);
        @(negedge clk);

        // Last command and restart
        send(8, 0, 0, 0, 0, 32'h10, 1);
        #1 chk("j_data", imem_wdata, 32'h0800_0010);
        @(negedge clk);
        #1;
        chk("j_done", 32'(done), 32'd1);
        chk("j_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        pulse_start();
        #1;
        chk("restart_count", 32'(word_count), 32'd0);
        chk("restart_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);

        // start during WRITE is ignored
        send(6, 3, 4, 0, 16'h1234, 0, 0);
        pulse_start();
        #1 chk("start_in_write", 32'(word_count), 32'd1);
        @(negedge clk);
        pulse_start();

        // Reset during WRITE suppresses the write
        send(1, 2, 3, 0, 8, 0, 0);
        rst = 1'b1;
        #1 chk("rst_mid_we", 32'(imem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_count", 32'(word_count), 32'd0);
        chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);

        // Randomized programs
        for (int p = 0; p < 40; p++) begin
            pulse_start();
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                op = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
                send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 65535), $urandom_range(0, 32'h3FF_FFFF), k == len - 1);
            end
            n = 0;
            while (!done && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("done_timeout", 32'(done), 32'd1);
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
